// File: rtl/mips_instr_issuer.sv
// rtl/mips_instr_issuer.sv - encodes MIPS field requests, queues them, issues each word to the core and returns the result
module mips_instr_issuer #(
    parameter int DEPTH         = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_fmt,
    input  logic [5:0]  req_code,
    input  logic [4:0]  req_rs,
    input  logic [4:0]  req_rt,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_shamt,
    input  logic [15:0] req_imm,
    output logic [31:0] instr_out,
    input  logic [31:0] core_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [31:0] rsp_instr,
    output logic        err_illegal,
    output logic        busy,
    output logic [15:0] issued_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    // Opcode 63 is unused by the core: no register write, and it forces a fresh opcode decode
    localparam logic [31:0] SEPARATOR = 32'hFC00_0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GAP    = 2'd1,
        SETTLE = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t        state;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [31:0]   cur_instr;
    logic [SW-1:0] settle_cnt;

    logic [31:0]   req_word;
    logic          req_legal;
    logic          req_fire;
    logic          push;
    logic          pop;

    always_comb begin
        req_word = {6'b0, req_rs, req_rt, req_rd, req_shamt, req_code};
        if (req_fmt) begin
            req_word = {req_code, req_rs, req_rt, req_imm};
        end
    end

    always_comb begin
        req_legal = 1'b0;
        if (req_fmt) begin
            case (req_code)
                6'd8, 6'd9, 6'd10, 6'd12, 6'd13, 6'd15: req_legal = 1'b1;
                default:                                 req_legal = 1'b0;
            endcase
        end else begin
            case (req_code)
                6'd0, 6'd2, 6'd3, 6'd32, 6'd34, 6'd36, 6'd37, 6'd43: req_legal = 1'b1;
                default:                                             req_legal = 1'b0;
            endcase
        end
    end

    // Ready comes only from the registered count, so a same-cycle pop never frees a full FIFO
    assign req_ready = (count != CW'(DEPTH));
    assign req_fire  = req_valid && req_ready;
    assign push      = req_fire && req_legal;
    assign pop       = (state == IDLE) && (count != '0);
    assign busy      = (state != IDLE) || (count != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= req_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            err_illegal <= 1'b0;
        end else begin
            err_illegal <= req_fire && !req_legal;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cur_instr    <= '0;
            settle_cnt   <= '0;
            instr_out    <= SEPARATOR;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            rsp_instr    <= '0;
            issued_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        cur_instr <= mem[rd_ptr];
                        instr_out <= SEPARATOR;
                        state     <= GAP;
                    end
                end
                GAP: begin
                    instr_out  <= cur_instr;
                    settle_cnt <= '0;
                    state      <= SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        rsp_data  <= core_result;
                        rsp_instr <= cur_instr;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        settle_cnt <= settle_cnt + SW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid    <= 1'b0;
                        issued_count <= issued_count + 16'd1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_instr_issuer.sv
// tb/tb_mips_instr_issuer.sv - randomized self-checking bench for mips_instr_issuer against a queue/ALU reference
module tb_mips_instr_issuer;

    localparam logic [31:0] SEP = 32'hFC00_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_fmt;
    logic [5:0]  req_code;
    logic [4:0]  req_rs;
    logic [4:0]  req_rt;
    logic [4:0]  req_rd;
    logic [4:0]  req_shamt;
    logic [15:0] req_imm;
    logic [31:0] instr_out;
    logic [31:0] core_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [31:0] rsp_instr;
    logic        err_illegal;
    logic        busy;
    logic [15:0] issued_count;
    logic [31:0] noise;

    mips_instr_issuer #(.DEPTH(4), .SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_fmt(req_fmt), .req_code(req_code),
        .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_shamt(req_shamt), .req_imm(req_imm),
        .instr_out(instr_out), .core_result(core_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_instr(rsp_instr),
        .err_illegal(err_illegal), .busy(busy), .issued_count(issued_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] encode(input logic fmt, input logic [5:0] code, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                                           input logic [15:0] imm);
        if (fmt) return {code, rs, rt, imm};
        return {6'b0, rs, rt, rd, sh, code};
    endfunction

    function automatic bit is_legal(input logic fmt, input logic [5:0] code);
        if (fmt) return code inside {6'd8, 6'd9, 6'd10, 6'd12, 6'd13, 6'd15};
        return code inside {6'd0, 6'd2, 6'd3, 6'd32, 6'd34, 6'd36, 6'd37, 6'd43};
    endfunction

    // Stand-in core: register i holds i+12, no write-back
    function automatic logic [31:0] core_fn(input logic [31:0] w);
        logic [31:0] rs, rt, se, ze;
        rs = 32'(w[25:21]) + 32'd12;
        rt = 32'(w[20:16]) + 32'd12;
        se = {{16{w[15]}}, w[15:0]};
        ze = {16'b0, w[15:0]};
        case (w[31:26])
            6'd0: begin
                case (w[5:0])
                    6'd0:    return rt << w[10:6];
                    6'd2:    return rt >> w[10:6];
                    6'd3:    return $signed(rt) >>> w[10:6];
                    6'd32:   return rs + rt;
                    6'd34:   return rs - rt;
                    6'd36:   return rs & rt;
                    6'd37:   return rs | rt;
                    6'd43:   return {31'b0, rs < rt};
                    default: return 32'hBAD0_0000;
                endcase
            end
            6'd8, 6'd9: return rs + se;
            6'd10:      return {31'b0, $signed(rs) < $signed(se)};
            6'd12:      return rs & ze;
            6'd13:      return rs | ze;
            6'd15:      return {w[15:0], 16'b0};
            default:    return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Once a response is pending the core output is scrambled; a late sample would notice
    assign core_result = core_fn(instr_out) ^ (rsp_valid ? noise : 32'h0);
    always @(posedge clk) noise <= $urandom | 32'h1;

    logic [31:0] exp_q[$];
    int          exp_issued;
    logic        err_due;
    logic [31:0] prev_instr;

    always @(negedge clk) begin
        logic [31:0] w;
        if (!rst_n) begin
            exp_q.delete();
            exp_issued = 0;
            err_due    = 1'b0;
            prev_instr = SEP;
        end else begin
            check("err_illegal", err_illegal, err_due);
            check("issued_count", issued_count, 32'(exp_issued[15:0]));
            if (instr_out !== prev_instr)
                check("sep_between_words", (prev_instr == SEP) || (instr_out == SEP), 1);
            prev_instr = instr_out;
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 1, 0);
                end else begin
                    w = exp_q.pop_front();
                    check("rsp_instr", rsp_instr, w);
                    check("rsp_data", rsp_data, core_fn(w));
                end
                exp_issued++;
            end
            err_due = req_valid && req_ready && !is_legal(req_fmt, req_code);
            if (req_valid && req_ready && is_legal(req_fmt, req_code))
                exp_q.push_back(encode(req_fmt, req_code, req_rs, req_rt, req_rd, req_shamt, req_imm));
        end
    end

    task automatic set_req(input logic fmt, input logic [5:0] code, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm);
        req_fmt = fmt; req_code = code; req_rs = rs; req_rt = rt; req_rd = rd; req_shamt = sh; req_imm = imm;
    endtask

    task automatic rand_req(input bit legal_only);
        logic [31:0] r;
        logic [5:0]  rc [8];
        logic [5:0]  ic [6];
        rc = '{6'd0, 6'd2, 6'd3, 6'd32, 6'd34, 6'd36, 6'd37, 6'd43};
        ic = '{6'd8, 6'd9, 6'd10, 6'd12, 6'd13, 6'd15};
        r = $urandom;
        req_fmt = r[0];
        if (legal_only || ($urandom % 5 != 0)) req_code = req_fmt ? ic[$urandom % 6] : rc[$urandom % 8];
        else req_code = r[6:1];
        r = $urandom;
        req_rs = r[4:0]; req_rt = r[9:5]; req_rd = r[14:10]; req_shamt = r[19:15];
        r = $urandom;
        req_imm = r[15:0];
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        set_req(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic wait_rsp(input string tag, output logic [31:0] data, output logic [31:0] instr);
        bit got = 0;
        data = '0; instr = '0;
        for (int c = 0; c < 60 && !got; c++) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) begin
                data = rsp_data; instr = rsp_instr; got = 1;
            end
        end
        if (!got) check({tag, "_timeout"}, 0, 1);
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [31:0] d, ins;
        logic [31:0] bp_words [5];
        logic [15:0] base;

        do_reset();
        rst_n = 1'b0;
        #1;
        check("reset_instr_out", instr_out, SEP);
        check("reset_req_ready", req_ready, 1);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_issued", issued_count, 0);
        check("reset_busy", busy, 0);
        do_reset();

        // R-type add with exact latency
        @(posedge clk); #2;
        set_req(1'b0, 6'd32, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0);
        req_valid = 1'b1; rsp_ready = 1'b1;
        @(negedge clk);
        check("add_req_ready", req_ready, 1);
        @(posedge clk); #2;
        req_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("add_rsp_valid_c%0d", k), rsp_valid, (k == 4));
            if (k == 1) check("add_gap_sep", instr_out, SEP);
            if (k == 2) check("add_instr_out", instr_out, 32'h0022_1820);
        end
        check("add_rsp_data", rsp_data, 32'd27);
        check("add_rsp_instr", rsp_instr, 32'h0022_1820);
        @(posedge clk);
        @(negedge clk);
        check("add_issued", issued_count, 1);
        check("add_rsp_cleared", rsp_valid, 0);

        // Back-to-back I-type
        @(posedge clk); #2;
        set_req(1'b1, 6'd8, 5'd0, 5'd5, 5'd0, 5'd0, 16'hFFFF);
        req_valid = 1'b1;
        @(posedge clk); #2;
        set_req(1'b1, 6'd15, 5'd0, 5'd7, 5'd0, 5'd0, 16'h1234);
        @(posedge clk); #2;
        req_valid = 1'b0;
        wait_rsp("addi", d, ins);
        check("addi_instr", ins, 32'h2005_FFFF);
        check("addi_data", d, 32'd11);
        wait_rsp("lui", d, ins);
        check("lui_instr", ins, 32'h3C07_1234);
        check("lui_data", d, 32'h1234_0000);

        // Illegal requests
        for (int t = 0; t < 2; t++) begin
            @(posedge clk); #2;
            if (t == 0) set_req(1'b0, 6'd1, 5'd1, 5'd2, 5'd3, 5'd0, 16'd0);
            else        set_req(1'b1, 6'd0, 5'd1, 5'd2, 5'd0, 5'd0, 16'h55);
            req_valid = 1'b1;
            @(posedge clk); #2;
            req_valid = 1'b0;
            @(negedge clk);
            check("illegal_pulse", err_illegal, 1);
            check("illegal_not_queued", busy, 0);
            @(negedge clk);
            check("illegal_pulse_end", err_illegal, 0);
        end

        // Backpressure: one in RESP, four in the FIFO, sixth refused
        rsp_ready = 1'b0;
        base = issued_count;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #2;
            rand_req(1'b1);
            req_valid = 1'b1;
            if (i < 5) bp_words[i] = encode(req_fmt, req_code, req_rs, req_rt, req_rd, req_shamt, req_imm);
            @(negedge clk);
            check($sformatf("bp_req_ready_%0d", i), req_ready, (i < 5));
        end
        @(posedge clk); #2;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("bp_rsp_held", rsp_valid, 1);
        check("bp_still_full", req_ready, 0);
        @(posedge clk); #2;
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_rsp("bp", d, ins);
            check($sformatf("bp_order_%0d", i), ins, bp_words[i]);
        end
        @(negedge clk);
        check("bp_issued", issued_count, 32'(base + 16'd5));

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #2;
            rand_req(1'b0);
            req_valid = ($urandom % 3 != 0);
            rsp_ready = ($urandom % 4 != 0);
        end
        @(posedge clk); #2;
        req_valid = 1'b0; rsp_ready = 1'b1;
        for (int c = 0; c < 200 && (busy || rsp_valid); c++) @(negedge clk);
        @(negedge clk);
        check("drain_idle", busy, 0);
        check("drain_scoreboard_empty", exp_q.size(), 0);

        // Reset during SETTLE with two entries queued
        for (int j = 0; j < 3; j++) begin
            @(posedge clk); #2;
            rand_req(1'b1);
            req_valid = 1'b1;
        end
        @(posedge clk); #2;
        req_valid = 1'b0;
        @(negedge clk);
        check("midreset_busy_before", busy, 1);
        #1 rst_n = 1'b0;
        #1;
        check("midreset_instr_out", instr_out, SEP);
        check("midreset_rsp_valid", rsp_valid, 0);
        check("midreset_busy", busy, 0);
        check("midreset_req_ready", req_ready, 1);
        check("midreset_issued", issued_count, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("post_reset_no_rsp", rsp_valid, 0);
            check("post_reset_idle", busy, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
